// File: rtl/burst_sdr_ctrl.sv
// Burst transfer sequencer for the serial shift-register datapath (SDR/SP/CNT).
// Runs one-direction byte bursts, owns the port direction and the per-byte timeout.
module burst_sdr_ctrl #(
    parameter int              LEN_W    = 8,
    parameter int              TO_W     = 16,
    parameter logic [TO_W-1:0] TIMEOUT  = 16'd50000,
    parameter int              TURN_CYC = 4
) (
    input  logic             E_CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [LEN_W-1:0] bytes_left,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             sp_output,
    output logic             sdr_wr,
    output logic [7:0]       sdr_wdata,
    input  logic             shift_done,
    input  logic [7:0]       sdr_rdata
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_TURN     = 3'd1;
    localparam logic [2:0] ST_TX_FETCH = 3'd2;
    localparam logic [2:0] ST_TX_SHIFT = 3'd3;
    localparam logic [2:0] ST_RX_SHIFT = 3'd4;
    localparam logic [2:0] ST_RX_HOLD  = 3'd5;
    localparam logic [2:0] ST_FINISH   = 3'd6;

    localparam int              TC_W      = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [TC_W-1:0] TURN_LOAD = TC_W'(TURN_CYC - 1);
    localparam logic [TC_W-1:0] TURN_ZERO = {TC_W{1'b0}};
    localparam logic [TC_W-1:0] TURN_ONE  = {{(TC_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_ZERO   = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST   = TIMEOUT - TO_ONE;
    localparam logic [LEN_W:0]  CNT_ZERO  = {(LEN_W+1){1'b0}};
    localparam logic [LEN_W:0]  CNT_ONE   = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0]  CNT_FULL  = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    logic [2:0]      state_r;
    logic [2:0]      state_s;
    logic            dir_r;
    logic [LEN_W:0]  cnt_r;
    logic [TC_W-1:0] turn_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            need_turn_s;
    logic            to_expire_s;
    logic            aborting_s;
    logic            cnt_last_s;

    // TX wants sp_output=1 (dir=0), RX wants 0 (dir=1): a turn is needed when they match
    assign need_turn_s = (sp_output == dir);
    assign to_expire_s = (to_cnt_r == TO_LAST);
    assign aborting_s  = abort && (state_r != ST_IDLE);
    assign cnt_last_s  = (cnt_r == CNT_ONE);
    assign tx_ready    = (state_r == ST_TX_FETCH);
    assign bytes_left  = cnt_r[LEN_W-1:0];

    // Next-state selection; abort overrides everything except IDLE and FINISH
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (need_turn_s) begin
                        state_s = ST_TURN;
                    end else if (dir) begin
                        state_s = ST_RX_SHIFT;
                    end else begin
                        state_s = ST_TX_FETCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (turn_cnt_r == TURN_ZERO) begin
                    state_s = dir_r ? ST_RX_SHIFT : ST_TX_FETCH;
                end else begin
                    state_s = ST_TURN;
                end
            end
            ST_TX_FETCH: begin
                if (tx_valid) begin
                    state_s = ST_TX_SHIFT;
                end else begin
                    state_s = ST_TX_FETCH;
                end
            end
            ST_TX_SHIFT: begin
                if (shift_done) begin
                    state_s = cnt_last_s ? ST_FINISH : ST_TX_FETCH;
                end else if (to_expire_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_TX_SHIFT;
                end
            end
            ST_RX_SHIFT: begin
                if (shift_done) begin
                    state_s = ST_RX_HOLD;
                end else if (to_expire_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_RX_SHIFT;
                end
            end
            ST_RX_HOLD: begin
                if (rx_ready) begin
                    state_s = cnt_last_s ? ST_FINISH : ST_RX_SHIFT;
                end else begin
                    state_s = ST_RX_HOLD;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
        if (aborting_s && (state_r != ST_FINISH)) begin
            state_s = ST_FINISH;
        end else begin
            state_s = state_s;
        end
    end

    // State, datapath and status registers
    always_ff @(posedge E_CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            sp_output   <= 1'b0;
            sdr_wr      <= 1'b0;
            sdr_wdata   <= 8'd0;
            dir_r       <= 1'b0;
            cnt_r       <= CNT_ZERO;
            turn_cnt_r  <= TURN_ZERO;
            to_cnt_r    <= TO_ZERO;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != ST_IDLE);
            done    <= (state_s == ST_FINISH);
            sdr_wr  <= 1'b0;

            // Timeout counter restarts on every state entry
            if (state_s != state_r) begin
                to_cnt_r <= TO_ZERO;
            end else if ((state_r == ST_TX_SHIFT) || (state_r == ST_RX_SHIFT)) begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end else begin
                to_cnt_r <= to_cnt_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dir_r       <= dir;
                        cnt_r       <= (len == LEN_ZERO) ? CNT_FULL : {1'b0, len};
                        err_timeout <= 1'b0;
                        err_overrun <= 1'b0;
                        if (need_turn_s) begin
                            sp_output  <= ~dir;
                            turn_cnt_r <= TURN_LOAD;
                        end
                    end
                end
                ST_TURN: begin
                    if (turn_cnt_r != TURN_ZERO) begin
                        turn_cnt_r <= turn_cnt_r - TURN_ONE;
                    end
                end
                ST_TX_FETCH: begin
                    if (tx_valid && !aborting_s) begin
                        sdr_wdata <= tx_data;
                        sdr_wr    <= 1'b1;
                    end
                end
                ST_TX_SHIFT: begin
                    if (!aborting_s) begin
                        if (shift_done) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else if (to_expire_s) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                ST_RX_SHIFT: begin
                    if (!aborting_s) begin
                        if (shift_done) begin
                            rx_data  <= sdr_rdata;
                            rx_valid <= 1'b1;
                        end else if (to_expire_s) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                ST_RX_HOLD: begin
                    // A byte finishing while the previous one is still held is lost
                    if (shift_done) begin
                        err_overrun <= 1'b1;
                    end
                    if (rx_ready && !aborting_s) begin
                        rx_valid <= 1'b0;
                        cnt_r    <= cnt_r - CNT_ONE;
                    end
                end
                ST_FINISH: sdr_wr <= 1'b0;
                default:   sdr_wr <= 1'b0;
            endcase

            if (aborting_s) begin
                sp_output <= 1'b0;
                rx_valid  <= 1'b0;
            end
        end
    end

endmodule
